// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: active-low segment
// patterns ordered {g,f,e,d,c,b,a}, digit count and the all-off anode pattern.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [6:0]            seg_t;
    typedef logic [NUM_DIGITS-1:0] an_t;

    localparam an_t  AN_OFF   = 4'b1111;

    localparam seg_t SEG_0    = 7'b1000000;
    localparam seg_t SEG_1    = 7'b1111001;
    localparam seg_t SEG_2    = 7'b0100100;
    localparam seg_t SEG_3    = 7'b0110000;
    localparam seg_t SEG_4    = 7'b0011001;
    localparam seg_t SEG_5    = 7'b0010010;
    localparam seg_t SEG_6    = 7'b0000010;
    localparam seg_t SEG_7    = 7'b1111000;
    localparam seg_t SEG_8    = 7'b0000000;
    localparam seg_t SEG_9    = 7'b0010000;
    localparam seg_t SEG_DASH = 7'b0111111;
    localparam seg_t SEG_OFF  = 7'b1111111;

    // One-cold anode pattern selecting digit idx.
    function automatic an_t an_select(input logic [1:0] idx);
        an_t pat;
        case (idx)
            2'd0:    pat = 4'b1110;
            2'd1:    pat = 4'b1101;
            2'd2:    pat = 4'b1011;
            2'd3:    pat = 4'b0111;
            default: pat = AN_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low segment pattern; values above 9
// render as a dash so bad data is visible rather than silently blank.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    // Nibble lookup
    always_comb begin
        o_seg = SEG_DASH;
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_driver.sv
// Four-digit common-anode display scanner with per-digit blank/blink/dp,
// a dark guard at the start of every slot, and fully registered pin outputs.
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int DIV_CYCLES   = 100000,
    parameter int GUARD_CYCLES = 16,
    parameter int BLINK_CYCLES = 25000000
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_digits,
    input  logic [3:0]  i_dp_en,
    input  logic [3:0]  i_blank,
    input  logic [3:0]  i_blink,
    input  logic        i_load,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp
);

    localparam int SLOT_W  = $clog2(DIV_CYCLES);
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIV_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  GUARD_LIM  = SLOT_W'(GUARD_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [SLOT_W-1:0]  r_slot_cnt;
    logic [1:0]         r_digit_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;

    logic [15:0]        r_sh_digits;
    logic [3:0]         r_sh_dp_en;
    logic [3:0]         r_sh_blank;
    logic [3:0]         r_sh_blink;

    an_t                r_an;
    seg_t               r_seg;
    logic               r_dp;

    logic [3:0]         w_nibble;
    seg_t               w_dec_seg;
    logic               w_dark;
    an_t                w_an_next;
    seg_t               w_seg_next;
    logic               w_dp_next;

    // Slot timing, digit index and free-running blink phase
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot_cnt    <= '0;
            r_digit_idx   <= 2'd0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (r_slot_cnt == SLOT_LAST) begin
                r_slot_cnt  <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
            end else begin
                r_slot_cnt  <= r_slot_cnt + SLOT_W'(1);
            end
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Shadow copy of the display contents; reset leaves every digit blanked
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh_digits <= 16'h0000;
            r_sh_dp_en  <= 4'b0000;
            r_sh_blank  <= 4'b1111;
            r_sh_blink  <= 4'b0000;
        end else if (i_load) begin
            r_sh_digits <= i_digits;
            r_sh_dp_en  <= i_dp_en;
            r_sh_blank  <= i_blank;
            r_sh_blink  <= i_blink;
        end
    end

    assign w_nibble = r_sh_digits[{r_digit_idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    assign w_dark = r_sh_blank[r_digit_idx]
                  | (r_sh_blink[r_digit_idx] & r_blink_phase)
                  | (r_slot_cnt < GUARD_LIM);

    // Next pin values from the current counters and shadows
    always_comb begin
        w_an_next  = AN_OFF;
        w_seg_next = SEG_OFF;
        w_dp_next  = 1'b1;
        if (w_dark) begin
            w_an_next  = AN_OFF;
            w_seg_next = SEG_OFF;
            w_dp_next  = 1'b1;
        end else begin
            w_an_next  = an_select(r_digit_idx);
            w_seg_next = w_dec_seg;
            w_dp_next  = ~r_sh_dp_en[r_digit_idx];
        end
    end

    // Pin registers; async reset forces the display dark without a clock
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign o_an  = r_an;
    assign o_seg = r_seg;
    assign o_dp  = r_dp;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: per-cycle reference model,
// table-driven slot checks and hand-written reset/blink/wrap/blank sequences.
module tb_seg_display_driver;

    localparam int DIV = 8;
    localparam int GRD = 2;
    localparam int BLK = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp_en, blank, blink;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    seg_display_driver #(
        .DIV_CYCLES   (DIV),
        .GUARD_CYCLES (GRD),
        .BLINK_CYCLES (BLK)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_digits (digits),
        .i_dp_en  (dp_en),
        .i_blank  (blank),
        .i_blink  (blink),
        .i_load   (load),
        .o_an     (an),
        .o_seg    (seg),
        .o_dp     (dp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: edges since reset release, and shadow contents
    int          m_k;
    int          out_k;
    logic [15:0] m_dig;
    logic [3:0]  m_dpe, m_blank, m_blink;

    string lit_tab [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic logic [6:0] pat(input string s);
        logic [6:0] r;
        r = 7'b1111111;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
        return r;
    endfunction

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        if (n < 4'd10) return pat(lit_tab[n]);
        return pat("g");
    endfunction

    function automatic logic [11:0] ref_out(input int k);
        int slot, idx, ph;
        logic [3:0] a;
        slot = k % DIV;
        idx  = (k / DIV) % 4;
        ph   = (k / BLK) % 2;
        if (m_blank[idx] || (m_blink[idx] && ph == 1) || slot < GRD)
            return {4'b1111, 7'b1111111, 1'b1};
        a = 4'b1111;
        a[idx] = 1'b0;
        return {a, ref_seg(m_dig[idx*4 +: 4]), ~m_dpe[idx]};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got an=%b seg=%b dp=%b, need an=%b seg=%b dp=%b",
                     name, $time, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_k = 0;
        m_dig = 16'h0000; m_dpe = 4'b0000; m_blank = 4'b1111; m_blink = 4'b0000;
    endtask

    // one clock: drive load, compare pins against the model just after the edge
    task automatic step(input logic ld);
        logic [11:0] e;
        load = ld;
        @(posedge clk);
        e = ref_out(m_k);
        out_k = m_k;
        m_k++;
        if (ld) begin
            m_dig = digits; m_dpe = dp_en; m_blank = blank; m_blink = blink;
        end
        #1;
        load = 1'b0;
        check("model", {an, seg, dp}, e);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_async", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_in(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl, input logic [3:0] bk);
        digits = d; dp_en = p; blank = bl; blink = bk;
    endtask

    typedef struct {
        logic [15:0]      dig;
        logic [3:0]       dpe;
        logic [3:0]       blk;
        logic [3:0][3:0]  an;
        logic [3:0][6:0]  seg;
        logic [3:0]       dp;
    } vec_t;

    vec_t vt [5];

    initial begin
        int c0, c1, c2, bad;
        logic [11:0] e;

        vt[0] = '{16'h1234, 4'b0000, 4'b0000,
                  {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
        vt[1] = '{16'h5678, 4'b1001, 4'b0000,
                  {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 4'b0110};
        vt[2] = '{16'hFEDC, 4'b0010, 4'b0000,
                  {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}, 4'b1101};
        vt[3] = '{16'h1234, 4'b0000, 4'b1010,
                  {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                  {7'b1111111, 7'b0100100, 7'b1111111, 7'b0011001}, 4'b1111};
        vt[4] = '{16'h0A00, 4'b0100, 4'b0000,
                  {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {7'b1000000, 7'b0111111, 7'b1000000, 7'b1000000}, 4'b1011};

        rst = 1'b0;
        load = 1'b0;
        set_in(16'h0000, 4'b0000, 4'b0000, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        check("reset_initial", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // scan, then reset asserted while digit 2 is lit
        set_in(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        step(1'b1);
        for (int i = 0; i < 64; i++) begin
            step(1'b0);
            if (an === 4'b1011) break;
        end
        check("lit_d2_before_rst", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b1});
        reset_pulse();
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b0);
            if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) bad++;
        end
        check_int("dark_after_reset", bad, 0);

        // table-driven slot contents (blink off, so phase does not matter)
        for (int v = 0; v < 5; v++) begin
            set_in(vt[v].dig, vt[v].dpe, vt[v].blk, 4'b0000);
            step(1'b1);
            for (int i = 0; i < 36; i++) begin
                step(1'b0);
                if (out_k % DIV == 5) begin
                    int idx;
                    idx = (out_k / DIV) % 4;
                    check($sformatf("table%0d_slot%0d", v, idx), {an, seg, dp},
                          {vt[v].an[idx], vt[v].seg[idx], vt[v].dp[idx]});
                end
            end
        end

        // load landing exactly on the 3->0 index wrap edge (digit 0 was 0)
        for (int i = 0; i < 40; i++) begin
            if (m_k % 32 == 31) break;
            step(1'b0);
        end
        check_int("wrap_aligned", m_k % 32, 31);
        set_in(16'h0009, 4'b0000, 4'b0000, 4'b0000);
        step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        check("wrap_load", {an, seg, dp}, {4'b1110, 7'b0010000, 1'b1});

        // blink on digit 0: lit only in every other 32-cycle window
        set_in(16'h1234, 4'b0000, 4'b0000, 4'b0001);
        step(1'b1);
        step(1'b0);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 128; i++) begin
            step(1'b0);
            if (an === 4'b1110) c0++;
            if (an === 4'b1101) c1++;
        end
        check_int("blink_d0_lit", c0, 12);
        check_int("blink_d1_lit", c1, 24);

        // blank digits 1 and 3
        set_in(16'h1234, 4'b0000, 4'b1010, 4'b0000);
        step(1'b1);
        step(1'b0);
        c0 = 0; c2 = 0; bad = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b0);
            if (an === 4'b1110) c0++;
            if (an === 4'b1011) c2++;
            if (an === 4'b1101 || an === 4'b0111) bad++;
        end
        check_int("blank_d0_lit", c0, 12);
        check_int("blank_d2_lit", c2, 12);
        check_int("blank_forbidden", bad, 0);

        // random loads against the model, with one more mid-run reset
        for (int i = 0; i < 800; i++) begin
            if (i == 400) reset_pulse();
            if ($urandom_range(7, 0) == 0) begin
                set_in(16'($urandom), 4'($urandom), 4'($urandom_range(15, 0) & $urandom_range(15, 0)),
                       4'($urandom));
                step(1'b1);
            end else begin
                step(1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_display_driver.md
# seg_display_driver

Drives the board's 4-digit, common-anode seven-segment display from internal BCD values. It is the outbound counterpart to the input synchronizers: those bring asynchronous board signals into the `clk` domain, and this block takes internal state back out to board pins. It time-multiplexes the four digits with a ghosting guard. It also supports per-digit blanking, blinking and decimal point. All outputs are registered and drive pins directly.

## Interface
- `DIV_CYCLES`, default 100000: clock cycles per digit slot. Must be ≥ 4.
- `GUARD_CYCLES`, default 16: cycles at the start of each slot with all anodes off. Must be < `DIV_CYCLES`.
- `BLINK_CYCLES`, default 25000000: cycles per blink half-period.
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, asynchronous and active-high.
- `digits` in 16: four BCD nibbles. Digit 0 (rightmost) is `[3:0]`; digit 3 is `[15:12]`.
- `dp_en` in 4: per-digit decimal point enable.
- `blank` in 4: per-digit force-off.
- `blink` in 4: per-digit blink enable.
- `load` in 1: single-cycle strobe that captures `digits`/`dp_en`/`blank`/`blink` into shadow registers.
- `an` out 4: anode enables, active-low. `an[i]` selects digit i.
- `seg` out 7: cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point cathode, active-low.

## Operation
- **Shadow registers.** `load`=1 at edge t updates the shadows at t. Without `load`, the shadows hold. Display logic reads only the shadows.
- **Slot counter.** Counts 0..`DIV_CYCLES`-1 and wraps. At the wrap, the digit index advances 0→1→2→3→0.
- **Blink.** A phase counter counts 0..`BLINK_CYCLES`-1. At its wrap, the blink phase bit toggles. The phase counter is free-running and independent of slot timing.
- **Digit dark.** The current digit i is dark when any of these holds:
  - `blank[i]`=1,
  - `blink[i]`=1 and blink phase = 1,
  - slot count < `GUARD_CYCLES`.
- **Dark outputs.** `an`=4'b1111, `seg`=7'b1111111, `dp`=1.
- **Lit outputs.**
  - `an` = the one-cold pattern for index i.
  - `seg` = the decode of nibble i.
  - `dp` = ~`dp_en[i]`.
- **Decode.** Nibbles 0–9 give standard digits. Nibbles 10–15 give a dash (g only, 7'b0111111).
- **Reset.**
  - Counters, index and blink phase go to 0.
  - Shadows go to: digits 0, `dp_en` 0, blink 0, blank 4'b1111. The display stays dark until the first `load`.
  - `an`=4'b1111, `seg`=7'b1111111, `dp`=1 immediately on `rst` assertion, regardless of `clk`.
- **Reset mid-slot** aborts the scan. After release, scanning restarts at digit 0, slot count 0.

## Timing
- **Output latency.** Outputs are registered: the outputs after edge t+1 reflect the counters and shadows after edge t.
- **`load` latency.** Data loaded at edge t appears on the pins after edge t+1.
- **Slot and frame.** Slot length is exactly `DIV_CYCLES`; a frame is 4·`DIV_CYCLES`. Each slot shows `GUARD_CYCLES` dark cycles, then `DIV_CYCLES`−`GUARD_CYCLES` lit cycles.
- **`load` at the slot wrap edge.** The new slot uses the newly loaded values.
- **Blink toggle mid-slot.** Takes effect within the slot, with the same one-cycle register latency.
- **No glitching.** At most one `an` bit is low in any cycle, and never across a digit change.

## Structure
- **Shared package `seg_pkg`.**
  - Constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF` (7-bit, active-low, {g..a}).
  - `NUM_DIGITS`=4.
  - `AN_OFF`=4'b1111.
- **Sub-module `seg7_decode`.** Combinational 4-bit nibble → 7-bit pattern, using the `seg_pkg` constants.
- **Top level.** Counters, shadows, blink phase, digit mux and output registers.

## Test plan
Bench parameters: `DIV_CYCLES`=8, `GUARD_CYCLES`=2, `BLINK_CYCLES`=32.

1. **Reset.**
   - Stimulus: assert `rst` between clock edges during lit digit 2.
   - Required: `an`=1111, `seg`=1111111, `dp`=1 immediately; after release, all outputs stay dark with no `load` for 64 cycles.
2. **Scan.**
   - Stimulus: `load` `digits`=16'h1234, `blank`=0.
   - Required, per slot: `an`=1110, `seg`=0011001 (4); `an`=1101, `seg`=0110000 (3); `an`=1011, `seg`=0100100 (2); `an`=0111, `seg`=1111001 (1).
   - Each slot has 2 dark cycles then 6 lit cycles; the pattern repeats every 32 cycles.
3. **Blink.**
   - Stimulus: `blink`=0001.
   - Required: digit 0 is lit only in frames where blink phase = 0 (alternating 32-cycle windows); digits 1–3 are unaffected.
4. **Dash and decimal point.**
   - Stimulus: `digits`=16'h0A00, `dp_en`=0100.
   - Required: in slot 2, `seg`=0111111 and `dp`=0; `dp`=1 in all other slots.
5. **`load` at slot wrap.**
   - Stimulus: `load` `digits`=16'h0009 on the edge where index goes 3→0.
   - Required: the digit 0 slot shows `seg`=0010000 (9), not the old value.
6. **Blank.**
   - Stimulus: `blank`=1010.
   - Required: `an` never takes 1101 or 0111; digits 0 and 2 display normally.
